// File: rtl/bitplane_raster_fifo.sv
// Bitplane-to-raster converter: prefetches RAM words over a valid/req handshake and
// unpacks them MSB-first into 1/2/4/8/16-bpp pixels with 1-4x horizontal repeat.
module bitplane_raster_fifo #(
    parameter  int DATA_W = 16,
    localparam int PTR_W  = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        pc_ena,
    input  logic              line_start,
    input  logic              pixel_in_ena,
    input  logic              enable_in,
    input  logic [2:0]        mode,
    input  logic [1:0]        h_scale,
    input  logic [7:0]        bg_colour,
    input  logic [9:0]        x_in,
    input  logic [DATA_W-1:0] word_in,
    input  logic              word_valid,
    output logic              word_req,
    output logic [15:0]       pixel_out,
    output logic              mode_16bit,
    output logic              pixel_out_ena,
    output logic              enable_out,
    output logic [9:0]        x_out,
    output logic              underrun
);

    logic [DATA_W-1:0] cur_word;
    logic [DATA_W-1:0] pref_word;
    logic              cur_empty;
    logic              buf_full;
    logic [PTR_W-1:0]  ptr;
    logic [1:0]        scale_cnt;

    logic              strobe;
    logic              active;
    logic [PTR_W:0]    bpp;
    logic [PTR_W:0]    ptr_sum;
    logic              wrap;
    logic [DATA_W-1:0] shifted;
    logic [15:0]       top_bits;
    logic [15:0]       pixel_val;

    assign word_req = ~buf_full;

    always_comb begin
        strobe = (pc_ena == 4'd0);
        bpp    = '0;
        case (mode)
            3'd1:    bpp = (PTR_W+1)'(1);
            3'd2:    bpp = (PTR_W+1)'(2);
            3'd3:    bpp = (PTR_W+1)'(4);
            3'd4:    bpp = (PTR_W+1)'(8);
            3'd5:    bpp = (PTR_W+1)'(16);
            default: bpp = '0;
        endcase
        active = (bpp != '0);

        // The current pixel always sits in the top bits after shifting the word left by ptr.
        shifted  = cur_word << ptr;
        top_bits = shifted[DATA_W-1 -: 16];

        pixel_val = 16'h0000;
        case (mode)
            3'd1:    pixel_val = {12'h000, top_bits[15] ? bg_colour[7:4] : bg_colour[3:0]};
            3'd2:    pixel_val = {8'h00, bg_colour[7:2], top_bits[15:14]};
            3'd3:    pixel_val = {8'h00, bg_colour[7:4], top_bits[15:12]};
            3'd4:    pixel_val = {8'h00, top_bits[15:8]};
            3'd5:    pixel_val = top_bits;
            default: pixel_val = 16'h0000;
        endcase

        ptr_sum = {1'b0, ptr} + bpp;
        // A mid-line mode change can leave ptr unaligned, so treat overshoot as a wrap too.
        wrap    = (ptr_sum >= (PTR_W+1)'(DATA_W));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_word      <= '0;
            pref_word     <= '0;
            cur_empty     <= 1'b1;
            buf_full      <= 1'b0;
            ptr           <= '0;
            scale_cnt     <= 2'd0;
            underrun      <= 1'b0;
            pixel_out     <= 16'h0000;
            mode_16bit    <= 1'b0;
            pixel_out_ena <= 1'b0;
            enable_out    <= 1'b0;
            x_out         <= 10'd0;
        end else begin
            if (!buf_full && word_valid) begin
                pref_word <= word_in;
                buf_full  <= 1'b1;
            end
            if (cur_empty && buf_full) begin
                cur_word  <= pref_word;
                ptr       <= '0;
                cur_empty <= 1'b0;
                buf_full  <= 1'b0;
            end

            if (strobe) begin
                x_out         <= x_in;
                pixel_out_ena <= pixel_in_ena;
                mode_16bit    <= (mode == 3'd5);

                if (line_start) begin
                    cur_empty  <= 1'b1;
                    buf_full   <= 1'b0;
                    ptr        <= '0;
                    scale_cnt  <= 2'd0;
                    underrun   <= 1'b0;
                    pixel_out  <= 16'h0000;
                    enable_out <= 1'b0;
                end else if (!pixel_in_ena || !enable_in || !active) begin
                    pixel_out  <= 16'h0000;
                    enable_out <= 1'b0;
                end else if (cur_empty) begin
                    pixel_out  <= {8'h00, bg_colour};
                    enable_out <= 1'b1;
                    underrun   <= 1'b1;
                end else begin
                    pixel_out  <= pixel_val;
                    enable_out <= 1'b1;
                    if (scale_cnt == h_scale) begin
                        scale_cnt <= 2'd0;
                        if (wrap) begin
                            ptr <= '0;
                            if (buf_full) begin
                                cur_word <= pref_word;
                                buf_full <= 1'b0;
                            end else begin
                                cur_empty <= 1'b1;
                            end
                        end else begin
                            ptr <= ptr_sum[PTR_W-1:0];
                        end
                    end else begin
                        scale_cnt <= scale_cnt + 2'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_bitplane_raster_fifo.sv
// Directed self-checking bench for bitplane_raster_fifo (DATA_W = 16).
module tb_bitplane_raster_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  pc_ena;
    logic        line_start;
    logic        pixel_in_ena;
    logic        enable_in;
    logic [2:0]  mode;
    logic [1:0]  h_scale;
    logic [7:0]  bg_colour;
    logic [9:0]  x_in;
    logic [15:0] word_in;
    logic        word_valid;
    logic        word_req;
    logic [15:0] pixel_out;
    logic        mode_16bit;
    logic        pixel_out_ena;
    logic        enable_out;
    logic [9:0]  x_out;
    logic        underrun;

    int passed = 0;
    int total  = 0;

    bitplane_raster_fifo #(.DATA_W(16)) dut (
        .clk(clk), .reset(reset), .pc_ena(pc_ena), .line_start(line_start),
        .pixel_in_ena(pixel_in_ena), .enable_in(enable_in), .mode(mode),
        .h_scale(h_scale), .bg_colour(bg_colour), .x_in(x_in),
        .word_in(word_in), .word_valid(word_valid), .word_req(word_req),
        .pixel_out(pixel_out), .mode_16bit(mode_16bit),
        .pixel_out_ena(pixel_out_ena), .enable_out(enable_out),
        .x_out(x_out), .underrun(underrun)
    );

    always #5 clk = ~clk;

    // One clock edge with the given pixel phase and line_start; outputs settle 1 ns later.
    task automatic applyStimulus(input logic [3:0] pc, input logic ls);
        pc_ena     = pc;
        line_start = ls;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        total++;
        assert (observed === expected) passed++;
        else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    endtask

    initial begin
        logic [15:0] exp_px;

        reset        = 1'b1;
        pc_ena       = 4'd1;
        line_start   = 1'b0;
        pixel_in_ena = 1'b0;
        enable_in    = 1'b0;
        mode         = 3'd0;
        h_scale      = 2'd0;
        bg_colour    = 8'h00;
        x_in         = 10'd0;
        word_in      = 16'h0000;
        word_valid   = 1'b0;
        applyStimulus(4'd1, 1'b0);
        applyStimulus(4'd0, 1'b0);
        reset = 1'b0;

        checkOutput("rst_word_req", {15'd0, word_req}, 16'h0001);
        checkOutput("rst_pixel", pixel_out, 16'h0000);
        checkOutput("rst_underrun", {15'd0, underrun}, 16'h0000);

        // T1: reset mid-line with a word held and another buffered
        mode = 3'd1; bg_colour = 8'hA3; pixel_in_ena = 1'b1; enable_in = 1'b1; x_in = 10'd5;
        word_valid = 1'b1; word_in = 16'h8001;
        applyStimulus(4'd1, 1'b0);
        applyStimulus(4'd1, 1'b0);
        applyStimulus(4'd1, 1'b0);
        word_valid = 1'b0;
        checkOutput("t1_buf_full", {15'd0, word_req}, 16'h0000);
        for (int i = 0; i < 5; i++) applyStimulus(4'd0, 1'b0);
        checkOutput("t1_pre_pixel", pixel_out, 16'h0003);
        checkOutput("t1_pre_x", {6'd0, x_out}, 16'd5);
        reset = 1'b1;
        applyStimulus(4'd0, 1'b0);
        reset = 1'b0;
        checkOutput("t1_pixel", pixel_out, 16'h0000);
        checkOutput("t1_enable", {15'd0, enable_out}, 16'h0000);
        checkOutput("t1_pix_ena", {15'd0, pixel_out_ena}, 16'h0000);
        checkOutput("t1_x", {6'd0, x_out}, 16'h0000);
        checkOutput("t1_word_req", {15'd0, word_req}, 16'h0001);
        checkOutput("t1_underrun", {15'd0, underrun}, 16'h0000);

        // T2: 1bpp, word 8001, bg A3
        word_valid = 1'b1; word_in = 16'h8001;
        applyStimulus(4'd1, 1'b0);
        word_valid = 1'b0;
        applyStimulus(4'd1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(4'd0, 1'b0);
            exp_px = (i == 0 || i == 15) ? 16'h000A : 16'h0003;
            checkOutput($sformatf("t2_px%0d", i), pixel_out, exp_px);
        end
        checkOutput("t2_enable", {15'd0, enable_out}, 16'h0001);

        // T3: 4bpp, bg 50, word 1234, h_scale 1, with a gap pixel mid-word
        applyStimulus(4'd0, 1'b1);
        checkOutput("t3_flush_px", pixel_out, 16'h0000);
        mode = 3'd3; bg_colour = 8'h50; h_scale = 2'd1;
        word_valid = 1'b1; word_in = 16'h1234;
        applyStimulus(4'd1, 1'b0);
        word_valid = 1'b0;
        applyStimulus(4'd1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            x_in = 10'(100 + i);
            applyStimulus(4'd0, 1'b0);
            exp_px = (i < 2) ? 16'h0051 : 16'h0052;
            checkOutput($sformatf("t3_px%0d", i), pixel_out, exp_px);
        end
        checkOutput("t3_x", {6'd0, x_out}, 16'd103);
        pixel_in_ena = 1'b0;
        applyStimulus(4'd0, 1'b0);
        checkOutput("t3_gap_px", pixel_out, 16'h0000);
        checkOutput("t3_gap_ena", {15'd0, pixel_out_ena}, 16'h0000);
        pixel_in_ena = 1'b1;
        for (int i = 4; i < 8; i++) begin
            applyStimulus(4'd0, 1'b0);
            exp_px = (i < 6) ? 16'h0053 : 16'h0054;
            checkOutput($sformatf("t3_px%0d", i), pixel_out, exp_px);
        end

        // T4: 16bpp back-to-back words
        applyStimulus(4'd0, 1'b1);
        mode = 3'd5; h_scale = 2'd0;
        word_valid = 1'b1; word_in = 16'hBEEF;
        applyStimulus(4'd1, 1'b0);
        checkOutput("t4_req_a", {15'd0, word_req}, 16'h0000);
        word_in = 16'hCAFE;
        applyStimulus(4'd1, 1'b0);
        checkOutput("t4_req_b", {15'd0, word_req}, 16'h0001);
        applyStimulus(4'd1, 1'b0);
        checkOutput("t4_req_c", {15'd0, word_req}, 16'h0000);
        word_valid = 1'b0;
        applyStimulus(4'd0, 1'b0);
        checkOutput("t4_px0", pixel_out, 16'hBEEF);
        checkOutput("t4_m16", {15'd0, mode_16bit}, 16'h0001);
        checkOutput("t4_req_d", {15'd0, word_req}, 16'h0001);
        applyStimulus(4'd0, 1'b0);
        checkOutput("t4_px1", pixel_out, 16'hCAFE);
        checkOutput("t4_underrun", {15'd0, underrun}, 16'h0000);
        applyStimulus(4'd3, 1'b0);
        checkOutput("t4_hold", pixel_out, 16'hCAFE);

        // T5: 8bpp underrun after one word
        applyStimulus(4'd0, 1'b1);
        mode = 3'd4; bg_colour = 8'h77;
        word_valid = 1'b1; word_in = 16'h12AB;
        applyStimulus(4'd1, 1'b0);
        word_valid = 1'b0;
        applyStimulus(4'd1, 1'b0);
        applyStimulus(4'd0, 1'b0);
        checkOutput("t5_px0", pixel_out, 16'h0012);
        applyStimulus(4'd0, 1'b0);
        checkOutput("t5_px1", pixel_out, 16'h00AB);
        checkOutput("t5_no_underrun", {15'd0, underrun}, 16'h0000);
        applyStimulus(4'd0, 1'b0);
        checkOutput("t5_bg0", pixel_out, 16'h0077);
        checkOutput("t5_bg_ena", {15'd0, enable_out}, 16'h0001);
        checkOutput("t5_underrun0", {15'd0, underrun}, 16'h0001);
        applyStimulus(4'd0, 1'b0);
        checkOutput("t5_bg1", pixel_out, 16'h0077);
        checkOutput("t5_underrun1", {15'd0, underrun}, 16'h0001);
        applyStimulus(4'd0, 1'b1);
        checkOutput("t5_cleared", {15'd0, underrun}, 16'h0000);
        checkOutput("t5_flush_px", pixel_out, 16'h0000);

        // T6: word_valid held while full, then line_start against a valid word
        bg_colour = 8'h5C;
        word_valid = 1'b1; word_in = 16'h1111;
        applyStimulus(4'd1, 1'b0);
        word_in = 16'h2222;
        applyStimulus(4'd1, 1'b0);
        applyStimulus(4'd1, 1'b0);
        word_in = 16'h3333;
        applyStimulus(4'd1, 1'b0);
        checkOutput("t6_req_full", {15'd0, word_req}, 16'h0000);
        applyStimulus(4'd0, 1'b0);
        checkOutput("t6_px0", pixel_out, 16'h0011);
        applyStimulus(4'd0, 1'b0);
        checkOutput("t6_px1", pixel_out, 16'h0011);
        checkOutput("t6_req_after_wrap", {15'd0, word_req}, 16'h0001);
        applyStimulus(4'd0, 1'b1);
        word_valid = 1'b0;
        checkOutput("t6_flush_req", {15'd0, word_req}, 16'h0001);
        checkOutput("t6_flush_px", pixel_out, 16'h0000);
        applyStimulus(4'd1, 1'b0);
        checkOutput("t6_req_idle", {15'd0, word_req}, 16'h0001);
        applyStimulus(4'd0, 1'b0);
        checkOutput("t6_bg", pixel_out, 16'h005C);
        checkOutput("t6_underrun", {15'd0, underrun}, 16'h0001);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
